// File: rtl/dram_banked_mp.sv
// Multi-port, multi-bank line-granular main-memory model: round-robin single grant per cycle,
// independently timed banks with separate read/write latency, recovery and byte-enable writes.
module dram_banked_mp #(
  parameter int LINE_SIZE  = 64,
  parameter int DEPTH      = 65536,
  parameter int NUM_BANKS  = 4,
  parameter int NUM_PORTS  = 2,
  parameter int RD_LATENCY = 10,
  parameter int WR_LATENCY = 8,
  parameter int RECOVERY   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*32-1:0]          req_addr,
  input  logic [NUM_PORTS*LINE_SIZE*8-1:0] req_wdata,
  input  logic [NUM_PORTS*LINE_SIZE-1:0]   req_be,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [NUM_PORTS*LINE_SIZE*8-1:0] resp_rdata,
  output logic [31:0]                      stat_reads,
  output logic [31:0]                      stat_writes,
  output logic [31:0]                      stat_conflict
);
  localparam int LB  = LINE_SIZE * 8;
  localparam int OFF = $clog2(LINE_SIZE);
  localparam int IDX = $clog2(DEPTH);
  localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RECOVER} bank_state_t;

  bank_state_t          st      [NUM_BANKS];
  logic [15:0]          cnt     [NUM_BANKS];
  logic [PW-1:0]        b_port  [NUM_BANKS];
  logic                 b_we    [NUM_BANKS];
  logic [IDX-1:0]       b_line  [NUM_BANKS];
  logic [LB-1:0]        b_wdata [NUM_BANKS];
  logic [LINE_SIZE-1:0] b_be    [NUM_BANKS];
  logic [NUM_PORTS-1:0] outstanding;
  logic [PW-1:0]        rr;

  // Storage holds the XOR difference from the power-on pattern, so the pattern
  // appears at time zero and a reset never disturbs committed data.
  logic [LB-1:0] delta [DEPTH] = '{default: '0};

  logic [IDX-1:0]       p_line [NUM_PORTS];
  logic [BW-1:0]        p_bank [NUM_PORTS];
  logic [NUM_PORTS-1:0] eligible;
  logic                 found;
  logic [PW-1:0]        win;
  logic                 conflict;
  logic                 unused_addr;

  logic [NUM_BANKS-1:0] acc, fire;
  logic [PW-1:0]        c_port  [NUM_BANKS];
  logic                 c_we    [NUM_BANKS];
  logic [IDX-1:0]       c_line  [NUM_BANKS];
  logic [LB-1:0]        c_wdata [NUM_BANKS];
  logic [LINE_SIZE-1:0] c_be    [NUM_BANKS];
  int                   n_rd, n_wr;

  function automatic logic [31:0] init_word(input logic [IDX-1:0] line);
    logic [15:0] v;
    v = 16'(line);
    return {v, ~v};
  endfunction

  function automatic logic [LB-1:0] init_line(input logic [IDX-1:0] line);
    logic [LB-1:0] r;
    for (int j = 0; j < LB / 32; j++) r[j*32 +: 32] = init_word(line);
    return r;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int n);
    logic [32:0] s;
    s = {1'b0, a} + 33'(n);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    eligible    = '0;
    conflict    = 1'b0;
    found       = 1'b0;
    win         = '0;
    req_ready   = '0;
    unused_addr = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      p_line[p]   = req_addr[p*32+OFF +: IDX];
      p_bank[p]   = p_line[p][BW-1:0] & BW'(NUM_BANKS - 1);
      unused_addr = unused_addr ^ (^req_addr[p*32 +: 32]);
      if (req_valid[p] && !outstanding[p]) begin
        if (st[p_bank[p]] == IDLE) eligible[p] = !rst;
        else conflict = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && eligible[PW'((int'(rr) + i) % NUM_PORTS)]) begin
        found = 1'b1;
        win   = PW'((int'(rr) + i) % NUM_PORTS);
      end
    end
    if (found) req_ready[win] = 1'b1;
  end

  // A one-cycle operation completes on its acceptance edge, straight from the request.
  always_comb begin
    n_rd = 0;
    n_wr = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      acc[b]     = found && (p_bank[win] == BW'(b));
      fire[b]    = 1'b0;
      c_port[b]  = b_port[b];
      c_we[b]    = b_we[b];
      c_line[b]  = b_line[b];
      c_wdata[b] = b_wdata[b];
      c_be[b]    = b_be[b];
      if (st[b] == BUSY && cnt[b] == 16'((b_we[b] ? WR_LATENCY : RD_LATENCY) - 1)) fire[b] = 1'b1;
      if (acc[b] && (req_we[win] ? WR_LATENCY : RD_LATENCY) == 1) begin
        fire[b]    = 1'b1;
        c_port[b]  = win;
        c_we[b]    = req_we[win];
        c_line[b]  = p_line[win];
        c_wdata[b] = req_wdata[int'(win)*LB +: LB];
        c_be[b]    = req_be[int'(win)*LINE_SIZE +: LINE_SIZE];
      end
      if (fire[b]) begin
        if (c_we[b]) n_wr++;
        else n_rd++;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st[b]      <= IDLE;
        cnt[b]     <= '0;
        b_port[b]  <= '0;
        b_we[b]    <= 1'b0;
        b_line[b]  <= '0;
        b_wdata[b] <= '0;
        b_be[b]    <= '0;
      end
      outstanding   <= '0;
      rr            <= '0;
      resp_valid    <= '0;
      resp_rdata    <= '0;
      stat_reads    <= '0;
      stat_writes   <= '0;
      stat_conflict <= '0;
    end else begin
      outstanding <= (outstanding & ~resp_valid) | req_ready;
      if (found) rr <= PW'((int'(win) + 1) % NUM_PORTS);
      resp_valid <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        case (st[b])
          IDLE: if (acc[b]) begin
            b_port[b]  <= win;
            b_we[b]    <= req_we[win];
            b_line[b]  <= p_line[win];
            b_wdata[b] <= req_wdata[int'(win)*LB +: LB];
            b_be[b]    <= req_be[int'(win)*LINE_SIZE +: LINE_SIZE];
            if (fire[b]) begin
              st[b]  <= (RECOVERY > 0) ? RECOVER : IDLE;
              cnt[b] <= 16'd1;
            end else begin
              st[b]  <= BUSY;
              cnt[b] <= 16'd1;
            end
          end
          BUSY: if (fire[b]) begin
            st[b]  <= (RECOVERY > 0) ? RECOVER : IDLE;
            cnt[b] <= 16'd1;
          end else begin
            cnt[b] <= cnt[b] + 16'd1;
          end
          RECOVER: if (cnt[b] == 16'(RECOVERY)) st[b] <= IDLE;
                   else cnt[b] <= cnt[b] + 16'd1;
          default: st[b] <= IDLE;
        endcase
        if (fire[b]) begin
          resp_valid[c_port[b]] <= 1'b1;
          if (!c_we[b]) resp_rdata[int'(c_port[b])*LB +: LB] <= init_line(c_line[b]) ^ delta[c_line[b]];
        end
      end
      stat_reads  <= sat_add(stat_reads, n_rd);
      stat_writes <= sat_add(stat_writes, n_wr);
      if (conflict) stat_conflict <= sat_add(stat_conflict, 1);
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (fire[b] && c_we[b]) begin
        for (int k = 0; k < LINE_SIZE; k++) begin
          if (c_be[b][k])
            delta[c_line[b]][k*8 +: 8] <= c_wdata[b][k*8 +: 8] ^ init_line(c_line[b])[k*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_banked_mp.sv
// Directed bench for dram_banked_mp: vector table of single-port transactions plus
// hand sequences for arbitration, bank recovery/conflicts and reset mid-operation.
module tb_dram_banked_mp;
  localparam int LB = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req_valid = '0, req_ready, req_we = '0, resp_valid;
  logic [63:0]   req_addr = '0;
  logic [1023:0] req_wdata = '0, resp_rdata;
  logic [127:0]  req_be = '0;
  logic [31:0]   stat_reads, stat_writes, stat_conflict;

  int checks = 0, failures = 0, cyc = 0;

  dram_banked_mp dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .stat_reads(stat_reads), .stat_writes(stat_writes),
    .stat_conflict(stat_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wb;
    logic [63:0] be;
    int          exp_lat;
    logic [31:0] exp_w0;
    logic [31:0] exp_w15;
  } vec_t;

  vec_t vt [9];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] addr,
                         input logic [7:0] wb, input logic [63:0] be);
    req_valid[p]             = 1'b1;
    req_we[p]                = we;
    req_addr[p*32 +: 32]     = addr;
    req_wdata[p*LB +: LB]    = {64{wb}};
    req_be[p*64 +: 64]       = be;
  endtask

  task automatic do_op(input string name, input int p, input logic we, input logic [31:0] addr,
                       input logic [7:0] wb, input logic [63:0] be,
                       output int lat, output logic [LB-1:0] rdata);
    int t_acc;
    bit got;
    set_req(p, we, addr, wb, be);
    #1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (req_ready[p]) got = 1;
      else step();
    end
    check32({name, "_accept_ready"}, 32'(req_ready), 32'(2'b01 << p));
    t_acc = cyc;
    step();
    req_valid[p] = 1'b0;
    got = 0;
    lat = -1;
    rdata = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (resp_valid[p]) begin
        got   = 1;
        lat   = cyc - t_acc;
        rdata = resp_rdata[p*LB +: LB];
      end else begin
        step();
      end
    end
    step();
    check32({name, "_pulse_end"}, 32'(resp_valid[p]), 32'd0);
  endtask

  initial begin
    int lat, t0, t1, r0, r1, pulses;
    logic [31:0] d0, d1;
    logic [LB-1:0] rd;

    vt[0] = '{0, 1'b0, 32'h0000_0040, 8'h00, 64'h0,                   10, 32'h0001FFFE, 32'h0001FFFE};
    vt[1] = '{0, 1'b1, 32'h0000_0140, 8'hAA, 64'h0000_0000_0000_000F,  8, 32'h0,        32'h0};
    vt[2] = '{0, 1'b0, 32'h0000_0140, 8'h00, 64'h0,                   10, 32'hAAAAAAAA, 32'h0005FFFA};
    vt[3] = '{1, 1'b0, 32'hFFFF_FFC0, 8'h00, 64'h0,                   10, 32'hFFFF0000, 32'hFFFF0000};
    vt[4] = '{1, 1'b1, 32'h0000_00C0, 8'h55, 64'hF000_0000_0000_0000,  8, 32'h0,        32'h0};
    vt[5] = '{1, 1'b0, 32'h0000_00C0, 8'h00, 64'h0,                   10, 32'h0003FFFC, 32'h55555555};
    vt[6] = '{0, 1'b0, 32'h0040_0040, 8'h00, 64'h0,                   10, 32'h0001FFFE, 32'h0001FFFE};
    vt[7] = '{0, 1'b1, 32'hFFFF_FFC0, 8'h11, 64'hFFFF_FFFF_FFFF_FFFF,  8, 32'h0,        32'h0};
    vt[8] = '{0, 1'b0, 32'h003F_FFC0, 8'h00, 64'h0,                   10, 32'h11111111, 32'h11111111};

    // Reset values, with requests already asserted.
    #2 rst = 1'b1;
    set_req(0, 1'b0, 32'h40, 8'h0, 64'h0);
    set_req(1, 1'b0, 32'h80, 8'h0, 64'h0);
    #1;
    check32("rst_ready", 32'(req_ready), 32'd0);
    check32("rst_resp_valid", 32'(resp_valid), 32'd0);
    check32("rst_rdata_zero", 32'(|resp_rdata), 32'd0);
    check32("rst_stat_reads", stat_reads, 32'd0);
    check32("rst_stat_conflict", stat_conflict, 32'd0);
    step();
    step();
    req_valid = '0;
    rst = 1'b0;
    step();

    // Two ports, distinct banks, same cycle: one grant per cycle.
    set_req(0, 1'b0, 32'h0000_0000, 8'h0, 64'h0);
    set_req(1, 1'b0, 32'h0000_0040, 8'h0, 64'h0);
    #1;
    check32("t3_ready_first", 32'(req_ready), 32'b01);
    t0 = cyc;
    step();
    req_valid[0] = 1'b0;
    #1;
    check32("t3_ready_second", 32'(req_ready), 32'b10);
    step();
    req_valid[1] = 1'b0;
    r0 = -1; r1 = -1; d0 = '0; d1 = '0;
    for (int i = 0; i < 30; i++) begin
      if (resp_valid[0] && r0 < 0) begin r0 = cyc; d0 = resp_rdata[31:0]; end
      if (resp_valid[1] && r1 < 0) begin r1 = cyc; d1 = resp_rdata[LB +: 32]; end
      step();
    end
    check32("t3_p0_latency", 32'(r0 - t0), 32'd10);
    check32("t3_p1_latency", 32'(r1 - t0), 32'd11);
    check32("t3_p0_data", d0, 32'h0000FFFF);
    check32("t3_p1_data", d1, 32'h0001FFFE);

    // Both ports to bank 2: second waits through BUSY and RECOVER.
    set_req(0, 1'b0, 32'h0000_0080, 8'h0, 64'h0);
    set_req(1, 1'b0, 32'h0000_0180, 8'h0, 64'h0);
    #1;
    check32("t4_ready_first", 32'(req_ready), 32'b01);
    t0 = cyc;
    step();
    req_valid[0] = 1'b0;
    #1;
    t1 = -1; r0 = -1; d0 = '0;
    for (int i = 0; i < 40 && t1 < 0; i++) begin
      if (resp_valid[0] && r0 < 0) begin r0 = cyc; d0 = resp_rdata[31:0]; end
      if (req_ready[1]) t1 = cyc;
      else step();
    end
    check32("t4_second_accept", 32'(t1 - t0), 32'd12);
    step();
    req_valid[1] = 1'b0;
    r1 = -1; d1 = '0;
    for (int i = 0; i < 30 && r1 < 0; i++) begin
      if (resp_valid[1]) begin r1 = cyc; d1 = resp_rdata[LB +: 32]; end
      else step();
    end
    check32("t4_p0_latency", 32'(r0 - t0), 32'd10);
    check32("t4_p1_latency", 32'(r1 - t1), 32'd10);
    check32("t4_p0_data", d0, 32'h0002FFFD);
    check32("t4_p1_data", d1, 32'h0006FFF9);
    check32("t4_stat_conflict", stat_conflict, 32'd11);
    check32("t4_stat_reads", stat_reads, 32'd4);
    check32("t4_stat_writes", stat_writes, 32'd0);

    // Vector table: latency and line contents per transaction.
    foreach (vt[i]) begin
      do_op($sformatf("v%0d", i), vt[i].port, vt[i].we, vt[i].addr, vt[i].wb, vt[i].be, lat, rd);
      check32($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      if (!vt[i].we) begin
        check32($sformatf("v%0d_word0", i), rd[31:0], vt[i].exp_w0);
        check32($sformatf("v%0d_word15", i), rd[511:480], vt[i].exp_w15);
      end
    end
    check32("tbl_stat_reads", stat_reads, 32'd10);
    check32("tbl_stat_writes", stat_writes, 32'd3);

    // Reset during an in-flight write: dropped, not committed.
    set_req(1, 1'b1, 32'h0000_0240, 8'hEE, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    t0 = -1;
    for (int i = 0; i < 40 && t0 < 0; i++) begin
      if (req_ready[1]) t0 = cyc;
      else step();
    end
    check32("t5_accept", 32'(req_ready), 32'b10);
    step();
    req_valid[1] = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    req_valid[1] = 1'b1;
    #1;
    check32("t5_ready_in_reset", 32'(req_ready), 32'd0);
    step();
    check32("t5_resp_in_reset", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    req_valid = '0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (resp_valid != 2'b00) pulses++;
    end
    check32("t5_no_response", 32'(pulses), 32'd0);
    check32("t5_stat_writes", stat_writes, 32'd0);
    do_op("t5_read", 0, 1'b0, 32'h0000_0240, 8'h0, 64'h0, lat, rd);
    check32("t5_read_latency", 32'(lat), 32'd10);
    check32("t5_line9_word0", rd[31:0], 32'h0009FFF6);
    check32("t5_line9_word15", rd[511:480], 32'h0009FFF6);
    check32("t5_stat_reads", stat_reads, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
